// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer beside the EX-stage ALU.
// Runs WIDTH shift-add or restoring-divide iterations on operand magnitudes, then fixes signs.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startE,
  input  logic [1:0]       opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             cancel,
  output logic             stall_o,
  output logic             busy_o,
  output logic             valid_o,
  output logic             hiwrite_o,
  output logic             lowrite_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_count;
  logic               r_isDiv;
  logic               r_negQ;
  logic               r_negR;
  logic               r_divZero;
  logic [WIDTH-1:0]   r_srcA;
  logic [WIDTH-1:0]   r_divisor;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_signedOp;
  logic               w_signA;
  logic               w_signB;
  logic               w_accept;
  logic               w_lastIter;
  logic [WIDTH-1:0]   w_magA;
  logic [WIDTH-1:0]   w_magB;
  logic [WIDTH:0]     w_remShift;
  logic [WIDTH-1:0]   w_remDiff;
  logic [2*WIDTH-1:0] w_accNext;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_resHi;
  logic [WIDTH-1:0]   w_resLo;

  // The most negative operand negates to itself, which reads correctly as an unsigned magnitude.
  assign w_signedOp = ~opE[0];
  assign w_signA    = w_signedOp & srcaE[WIDTH-1];
  assign w_signB    = w_signedOp & srcbE[WIDTH-1];
  assign w_magA     = w_signA ? -srcaE : srcaE;
  assign w_magB     = w_signB ? -srcbE : srcbE;

  assign w_accept   = (r_state != BUSY) & startE & ~cancel;
  assign w_lastIter = (r_count == CW'(WIDTH - 1));

  // Divide keeps the partial remainder in the upper half and the dividend/quotient in the lower half.
  assign w_remShift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_remDiff  = w_remShift[WIDTH-1:0] - r_divisor;

  always_comb begin
    w_accNext = r_acc;
    if (r_isDiv) begin
      if (w_remShift >= {1'b0, r_divisor}) begin
        w_accNext = {w_remDiff, r_acc[WIDTH-2:0], 1'b1};
      end else begin
        w_accNext = {w_remShift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
      end
    end else if (r_mplier[0]) begin
      w_accNext = r_acc + r_mcand;
    end
  end

  assign w_prod = r_negQ ? -w_accNext : w_accNext;
  assign w_quo  = w_accNext[WIDTH-1:0];
  assign w_rem  = w_accNext[2*WIDTH-1:WIDTH];

  always_comb begin
    w_resHi = w_prod[2*WIDTH-1:WIDTH];
    w_resLo = w_prod[WIDTH-1:0];
    if (r_isDiv) begin
      if (r_divZero) begin
        w_resHi = r_srcA;
        w_resLo = '1;
      end else begin
        w_resHi = r_negR ? -w_rem : w_rem;
        w_resLo = r_negQ ? -w_quo : w_quo;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_isDiv   <= 1'b0;
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
      r_divZero <= 1'b0;
      r_srcA    <= '0;
      r_divisor <= '0;
      r_mplier  <= '0;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_state   <= BUSY;
            r_count   <= '0;
            r_isDiv   <= opE[1];
            r_negQ    <= w_signA ^ w_signB;
            r_negR    <= w_signA;
            r_divZero <= (srcbE == '0);
            r_srcA    <= srcaE;
            r_divisor <= w_magB;
            r_mplier  <= w_magB;
            r_mcand   <= {{WIDTH{1'b0}}, w_magA};
            r_acc     <= opE[1] ? {{WIDTH{1'b0}}, w_magA} : '0;
          end else begin
            r_state <= IDLE;
          end
        end
        BUSY: begin
          if (cancel) begin
            r_state <= IDLE;
          end else begin
            r_acc    <= w_accNext;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + CW'(1);
            if (w_lastIter) begin
              r_state <= DONE;
              r_hi    <= w_resHi;
              r_lo    <= w_resLo;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy_o    = (r_state == BUSY);
  assign valid_o   = (r_state == DONE);
  assign hiwrite_o = valid_o;
  assign lowrite_o = valid_o;
  assign stall_o   = busy_o | w_accept;
  assign hi_o      = r_hi;
  assign lo_o      = r_lo;

endmodule
